// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - arb_state_e : FSM state encoding for uart_tx_arbiter
//   - Default*    : default parameter values for requester count and timeouts
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOwned,
    StStart,
    StWaitAck,
    StWaitDone
  } arb_state_e;

  localparam int unsigned DefaultNumReq      = 2;
  localparam int unsigned DefaultHoldTimeout = 1024;
  localparam int unsigned DefaultAckTimeout  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i  : request vector
//   last_i : one-hot previous owner; the search starts one position above it
//   gnt_o  : one-hot winner, all zero when nothing is requested
//   any_o  : at least one request present
module rr_arbiter #(
  parameter int unsigned NumReq = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] last_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              any_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // Walk offsets 1..NumReq from the previous owner; offset NumReq wraps back
    // to the previous owner itself, so it only wins when it is the sole requester.
    for (int unsigned off = 1; off <= NumReq; off++) begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (last_i[k] && !found && req_i[(k + off) % NumReq]) begin
          gnt_o[(k + off) % NumReq] = 1'b1;
          found                     = 1'b1;
        end
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NUM_REQ byte-stream requesters.
// Grants round-robin and holds the grant for a whole message (up to a byte
// flagged with last), so messages from different requesters never interleave.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid_i      : per-requester byte valid
//   req_data_i       : per-requester byte, requester k on bits [8k+7:8k]
//   req_last_i       : byte ends the requester's message
//   req_ready_o      : byte accepted on valid & ready at a rising edge
//   grant_o          : one-hot current owner, zero when idle
//   tx_data_o        : byte to uart_tx.data_i
//   tx_valid_o       : one-cycle start pulse to uart_tx.valid_i
//   tx_busy_i        : uart_tx.busy_o
//   ack_err_o        : pulse when uart_tx never acknowledged a start pulse
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DefaultNumReq,
  parameter int unsigned HOLD_TIMEOUT = DefaultHoldTimeout,
  parameter int unsigned ACK_TIMEOUT  = DefaultAckTimeout
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_busy_i,
  output logic                 ack_err_o
);

  localparam int unsigned HoldW = $clog2(HOLD_TIMEOUT + 1);
  localparam int unsigned AckW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [HoldW-1:0]   HoldMax      = HoldW'(HOLD_TIMEOUT);
  localparam logic [AckW-1:0]    AckLast      = AckW'(ACK_TIMEOUT - 1);
  // Previous owner starts as the top requester so requester 0 wins first.
  localparam logic [NUM_REQ-1:0] LastOwnerRst = NUM_REQ'(1) << (NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0]   last_owner_q, last_owner_d;
  logic                 last_q, last_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [AckW-1:0]      ack_cnt_q, ack_cnt_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic                 pick_any;

  logic                 own_valid;
  logic                 own_last;
  logic [7:0]           own_data;

  rr_arbiter #(
    .NumReq(NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .last_i(last_owner_q),
    .gnt_o (pick_oh),
    .any_o (pick_any)
  );

  // Select the current owner's request lines.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner_q[k]) begin
        own_valid = req_valid_i[k];
        own_last  = req_last_i[k];
        own_data  = req_data_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    last_d       = last_q;
    tx_data_d    = tx_data_q;
    hold_cnt_d   = hold_cnt_q;
    ack_cnt_d    = '0;
    grant_o      = '0;
    req_ready_o  = '0;
    tx_valid_o   = 1'b0;
    ack_err_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        hold_cnt_d = '0;
        if (pick_any) begin
          owner_d = pick_oh;
          state_d = StOwned;
        end
      end

      StOwned: begin
        grant_o = owner_q;
        if (!tx_busy_i) begin
          req_ready_o = owner_q;
        end
        if (own_valid && !tx_busy_i) begin
          tx_data_d  = own_data;
          last_d     = own_last;
          hold_cnt_d = '0;
          state_d    = StStart;
        end else if (hold_cnt_q == HoldMax) begin
          // Owner stalled mid-message too long: revoke and move the rr pointer.
          last_owner_d = owner_q;
          hold_cnt_d   = '0;
          state_d      = StIdle;
        end else if (own_valid) begin
          hold_cnt_d = '0;
        end else begin
          // Cannot wrap: reaching HoldMax leaves this state on the next cycle.
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      StStart: begin
        grant_o    = owner_q;
        tx_valid_o = 1'b1;
        state_d    = StWaitAck;
      end

      StWaitAck: begin
        grant_o = owner_q;
        if (tx_busy_i) begin
          state_d = StWaitDone;
        end else if (ack_cnt_q == AckLast) begin
          // No acknowledge from uart_tx; treat the byte as sent.
          ack_err_o = 1'b1;
          state_d   = StWaitDone;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end

      StWaitDone: begin
        grant_o = owner_q;
        if (!tx_busy_i) begin
          if (last_q) begin
            last_owner_d = owner_q;
            state_d      = StIdle;
          end else begin
            hold_cnt_d = '0;
            state_d    = StOwned;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= LastOwnerRst;
      last_q       <= 1'b0;
      tx_data_q    <= '0;
      hold_cnt_q   <= '0;
      ack_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
      hold_cnt_q   <= hold_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
    end
  end

  assign tx_data_o = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with two requesters and a simple
// uart_tx busy model. Expected bytes and owners go into a scoreboard queue
// when stimulus is set up and are compared on every tx_valid_o pulse.
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq = 2;
  localparam int          Frame  = 10;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] gnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rv0 = 1'b0, rv1 = 1'b0;
  logic [7:0]   rd0 = '0, rd1 = '0;
  logic         rl0 = 1'b0, rl1 = 1'b0;
  logic [1:0]   req_ready;
  logic [1:0]   grant;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_busy;
  logic         ack_err;

  logic         busy_en = 1'b1;
  logic         ext_busy = 1'b0;
  logic         model_busy;
  int           busy_left;

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           n_pulse = 0;
  int           n_err = 0;
  int           vld_cyc = 0;
  int           err_cyc = 0;
  logic         prev_v;

  beat_t        q0[$];
  beat_t        q1[$];
  exp_t         sb[$];

  assign tx_busy = model_busy | ext_busy;

  uart_tx_arbiter #(
    .NUM_REQ     (NumReq),
    .HOLD_TIMEOUT(1024),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i({rv1, rv0}),
    .req_data_i ({rd1, rd0}),
    .req_last_i ({rl1, rl0}),
    .req_ready_o(req_ready),
    .grant_o    (grant),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_busy_i  (tx_busy),
    .ack_err_o  (ack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy rises the edge after a start pulse, lasts Frame cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left  <= 0;
      model_busy <= 1'b0;
    end else if (busy_left > 0) begin
      busy_left  <= busy_left - 1;
      model_busy <= (busy_left > 1);
    end else if (tx_valid && busy_en) begin
      busy_left  <= Frame;
      model_busy <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard compare on each start pulse, plus grant/ready sanity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid) begin
        n_pulse <= n_pulse + 1;
        vld_cyc <= cyc;
        check_eq("valid_single_cycle", 32'(prev_v), 32'd0);
        if (sb.size() == 0) begin
          check_eq("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          check_eq("tx_data", 32'(tx_data), 32'(sb[0].d));
          check_eq("tx_owner", 32'(grant), 32'(sb[0].gnt));
          void'(sb.pop_front());
        end
      end
      if (ack_err) begin
        n_err   <= n_err + 1;
        err_cyc <= cyc;
      end
      if (grant != 2'b00) begin
        check_eq("foreign_ready", 32'(req_ready & ~grant), 32'd0);
        check_eq("grant_onehot", 32'($countones(grant)), 32'd1);
      end
    end
    prev_v <= tx_valid;
  end

  task automatic expect_byte(input logic [7:0] d, input int k);
    exp_t e;
    e.d   = d;
    e.gnt = 2'(1 << k);
    sb.push_back(e);
  endtask

  task automatic add(input int k, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    if (k == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  // Present queued beats on both requesters until all are accepted or the
  // cycle budget runs out.
  task automatic run(input int budget, output int n, output bit to);
    logic hs0, hs1;
    n  = 0;
    to = 1'b0;
    while (q0.size() + q1.size() > 0) begin
      if (n >= budget) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      rv0 = (q0.size() > 0);
      rv1 = (q1.size() > 0);
      if (rv0) begin rd0 = q0[0].d; rl0 = q0[0].l; end
      if (rv1) begin rd1 = q1[0].d; rl1 = q1[0].l; end
      hs0 = rv0 && req_ready[0];
      hs1 = rv1 && req_ready[1];
      @(posedge clk);
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      n++;
    end
    @(negedge clk);
    rv0 = 1'b0;
    rv1 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || grant != 2'b00 || tx_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n < 500), 32'd1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int  n;
    bit  to;
    int  p0;
    int  e0;

    // Reset state
    reset_dut();
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_ackerr", 32'(ack_err), 32'd0);

    // Single byte
    p0 = n_pulse;
    add(0, 8'h41, 1'b1);
    expect_byte(8'h41, 0);
    run(100, n, to);
    check_eq("single_to", 32'(to), 32'd0);
    drain("single_drain");
    check_eq("single_pulses", 32'(n_pulse - p0), 32'd1);
    check_eq("single_grant_rel", 32'(grant), 32'd0);

    // No interleaving: "Hel" from req0, 'B' from req1, same cycle
    reset_dut();
    add(0, 8'h48, 1'b0); add(0, 8'h65, 1'b0); add(0, 8'h6C, 1'b1);
    add(1, 8'h42, 1'b1);
    expect_byte(8'h48, 0); expect_byte(8'h65, 0); expect_byte(8'h6C, 0);
    expect_byte(8'h42, 1);
    run(400, n, to);
    check_eq("inter_to", 32'(to), 32'd0);
    drain("inter_drain");

    // Fairness: continuous single-byte messages from both
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      add(0, 8'h61 + 8'(i), 1'b1);
      add(1, 8'h78 + 8'(i), 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      expect_byte(8'h61 + 8'(i), 0);
      expect_byte(8'h78 + 8'(i), 1);
    end
    run(600, n, to);
    check_eq("fair_to", 32'(to), 32'd0);
    drain("fair_drain");

    // uart_tx busy with an external user: owner's ready stays low
    reset_dut();
    ext_busy = 1'b1;
    add(0, 8'h77, 1'b1);
    expect_byte(8'h77, 0);
    run(20, n, to);
    check_eq("extbusy_blocked", 32'(to), 32'd1);
    check_eq("extbusy_ready", 32'(req_ready), 32'd0);
    check_eq("extbusy_grant", 32'(grant), 32'd1);
    ext_busy = 1'b0;
    run(100, n, to);
    check_eq("extbusy_to", 32'(to), 32'd0);
    drain("extbusy_drain");

    // Hold timeout: req0 stalls mid-message, req1 waits
    reset_dut();
    add(0, 8'h48, 1'b0);
    expect_byte(8'h48, 0);
    run(100, n, to);
    check_eq("hold_first_to", 32'(to), 32'd0);
    add(1, 8'h42, 1'b1);
    expect_byte(8'h42, 1);
    run(3000, n, to);
    check_eq("hold_to", 32'(to), 32'd0);
    check_eq("hold_not_early", 32'(n >= 1024), 32'd1);
    check_eq("hold_not_late", 32'(n <= 1024 + Frame + 10), 32'd1);
    drain("hold_drain");

    // ACK timeout: uart_tx never raises busy
    reset_dut();
    busy_en = 1'b0;
    e0 = n_err;
    add(0, 8'h55, 1'b1);
    expect_byte(8'h55, 0);
    run(100, n, to);
    check_eq("ack_run_to", 32'(to), 32'd0);
    drain("ack_drain");
    check_eq("ack_err_count", 32'(n_err - e0), 32'd1);
    check_eq("ack_err_delay", 32'(err_cyc - vld_cyc), 32'd16);
    busy_en = 1'b1;

    // Reset during WAIT_DONE, then req0 wins first
    reset_dut();
    add(0, 8'h33, 1'b1);
    expect_byte(8'h33, 0);
    run(100, n, to);
    n = 0;
    while (!model_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrst_busy_seen", 32'(model_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_ready", 32'(req_ready), 32'd0);
    check_eq("midrst_data", 32'(tx_data), 32'd0);
    check_eq("midrst_valid", 32'(tx_valid), 32'd0);
    check_eq("midrst_ackerr", 32'(ack_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    add(1, 8'h51, 1'b1);
    add(0, 8'h50, 1'b1);
    expect_byte(8'h50, 0);
    expect_byte(8'h51, 1);
    run(300, n, to);
    check_eq("midrst_to", 32'(to), 32'd0);
    drain("midrst_drain");

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
